// File: rtl/o_upd_seq_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// o_upd_seq_ctrl_if : tile-stat, datapath and coefficient bundle for the
//                     flash-attention output-rescale sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
interface o_upd_seq_ctrl_if #(
  parameter int D_W = 8,
  parameter int TIL = 16
);
  logic                      I_START;
  logic                      I_TILE_VLD;
  logic                      O_TILE_RDY;
  logic [TIL-1:0][2*D_W-1:0] I_LI_NEW;
  logic [TIL-1:0][D_W-1:0]   I_MI_NEW;
  logic                      O_UPD_ENA;
  logic [TIL-1:0][2*D_W-1:0] O_LI_OLD;
  logic [TIL-1:0][D_W-1:0]   O_MI_OLD;
  logic [TIL-1:0][2*D_W-1:0] O_LI_NEW;
  logic [TIL-1:0][D_W-1:0]   O_MI_NEW;
  logic                      I_UPD_VLD;
  logic [TIL-1:0][D_W-1:0]   I_COEF;
  logic                      O_COEF_VLD;
  logic                      I_COEF_RDY;
  logic [TIL-1:0][D_W-1:0]   O_COEF;
  logic                      O_FIRST;
  logic                      O_ERR;
  logic                      O_BUSY;
  logic                      O_DONE;
  logic [TIL-1:0][2*D_W-1:0] O_LI_FINAL;
  logic [TIL-1:0][D_W-1:0]   O_MI_FINAL;

  modport master (
    input  I_START, I_TILE_VLD, I_LI_NEW, I_MI_NEW, I_UPD_VLD, I_COEF, I_COEF_RDY,
    output O_TILE_RDY, O_UPD_ENA, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW,
           O_COEF_VLD, O_COEF, O_FIRST, O_ERR, O_BUSY, O_DONE, O_LI_FINAL, O_MI_FINAL
  );

  modport slave (
    output I_START, I_TILE_VLD, I_LI_NEW, I_MI_NEW, I_UPD_VLD, I_COEF, I_COEF_RDY,
    input  O_TILE_RDY, O_UPD_ENA, O_LI_OLD, O_MI_OLD, O_LI_NEW, O_MI_NEW,
           O_COEF_VLD, O_COEF, O_FIRST, O_ERR, O_BUSY, O_DONE, O_LI_FINAL, O_MI_FINAL
  );
endinterface
`default_nettype wire

// File: rtl/o_upd_seq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// o_upd_seq_ctrl : walks the K/V tiles of one query block, keeps l_i/m_i and
//                  forwards per-tile rescale coefficients downstream
// Rev 1.0
// ----------------------------------------------------------------------------
module o_upd_seq_ctrl #(
  parameter int D_W       = 8,
  parameter int TIL       = 16,
  parameter int NUM_TILES = 4,
  parameter int TMO       = 63
) (
  input wire               I_CLK,
  input wire               I_RST_N,
  o_upd_seq_ctrl_if.master bus
);

  localparam int TC_W = $clog2(NUM_TILES + 1);
  localparam int CC_W = $clog2(TMO + 1);
  localparam logic [TC_W-1:0] c_LAST = TC_W'(NUM_TILES - 1);
  localparam logic [CC_W-1:0] c_TMO  = CC_W'(TMO);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TILE = 3'd1,
    S_CALC      = 3'd2,
    S_EMIT      = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [TC_W-1:0]           r_tile_cnt;
  logic [CC_W-1:0]           r_cyc_cnt;
  logic [TIL-1:0][2*D_W-1:0] r_li_old;
  logic [TIL-1:0][D_W-1:0]   r_mi_old;
  logic [TIL-1:0][2*D_W-1:0] r_li_new;
  logic [TIL-1:0][D_W-1:0]   r_mi_new;
  logic [TIL-1:0][D_W-1:0]   r_coef;
  logic                      r_first;
  logic                      r_err;
  logic [TIL-1:0][2*D_W-1:0] r_li_fin;
  logic [TIL-1:0][D_W-1:0]   r_mi_fin;

  logic w_start;
  logic w_cap;
  logic w_calc_ok;
  logic w_calc_to;
  logic w_hs;
  logic w_last;
  logic w_tile_rdy;
  logic w_upd_ena;
  logic w_coef_vld;
  logic w_done;

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_start    = 1'b0;
    w_cap      = 1'b0;
    w_calc_ok  = 1'b0;
    w_calc_to  = 1'b0;
    w_hs       = 1'b0;
    w_last     = 1'b0;
    w_tile_rdy = 1'b0;
    w_upd_ena  = 1'b0;
    w_coef_vld = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.I_START) begin
          w_start = 1'b1;
          w_nxt   = S_WAIT_TILE;
        end
      end
      S_WAIT_TILE: begin
        w_tile_rdy = 1'b1;
        if (bus.I_TILE_VLD) begin
          w_cap = 1'b1;
          // The first tile has nothing to rescale, so the datapath is skipped.
          if (r_tile_cnt == '0) begin
            w_nxt = S_EMIT;
          end else begin
            w_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_upd_ena = 1'b1;
        if (bus.I_UPD_VLD) begin
          w_calc_ok = 1'b1;
          w_nxt     = S_EMIT;
        end else if (r_cyc_cnt == c_TMO) begin
          w_calc_to = 1'b1;
          w_nxt     = S_EMIT;
        end
      end
      S_EMIT: begin
        w_coef_vld = 1'b1;
        if (bus.I_COEF_RDY) begin
          w_hs   = 1'b1;
          w_last = (r_tile_cnt == c_LAST);
          if (w_last) begin
            w_nxt = S_DONE;
          end else begin
            w_nxt = S_WAIT_TILE;
          end
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_nxt  = S_IDLE;
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      r_tile_cnt <= '0;
      r_cyc_cnt  <= '0;
      r_li_old   <= '0;
      r_mi_old   <= '0;
      r_li_new   <= '0;
      r_mi_new   <= '0;
      r_coef     <= '0;
      r_first    <= 1'b0;
      r_err      <= 1'b0;
      r_li_fin   <= '0;
      r_mi_fin   <= '0;
    end else begin
      if (w_start) begin
        r_li_old   <= '0;
        r_mi_old   <= '0;
        r_tile_cnt <= '0;
        r_err      <= 1'b0;
      end
      if (w_cap) begin
        r_li_new  <= bus.I_LI_NEW;
        r_mi_new  <= bus.I_MI_NEW;
        r_cyc_cnt <= '0;
        if (r_tile_cnt == '0) begin
          r_coef  <= '0;
          r_first <= 1'b1;
        end
      end
      if (w_upd_ena && !w_calc_ok && !w_calc_to) begin
        r_cyc_cnt <= r_cyc_cnt + 1'b1;
      end
      // A result arriving on the timeout cycle still counts as a result.
      if (w_calc_ok) begin
        r_coef  <= bus.I_COEF;
        r_first <= 1'b0;
      end
      if (w_calc_to) begin
        r_coef  <= '0;
        r_first <= 1'b0;
        r_err   <= 1'b1;
      end
      if (w_hs) begin
        r_li_old   <= r_li_new;
        r_mi_old   <= r_mi_new;
        r_tile_cnt <= r_tile_cnt + 1'b1;
        if (w_last) begin
          r_li_fin <= r_li_new;
          r_mi_fin <= r_mi_new;
        end
      end
    end
  end

  assign bus.O_TILE_RDY = w_tile_rdy;
  assign bus.O_UPD_ENA  = w_upd_ena;
  assign bus.O_COEF_VLD = w_coef_vld;
  assign bus.O_DONE     = w_done;
  assign bus.O_BUSY     = (r_state != S_IDLE);
  assign bus.O_LI_OLD   = r_li_old;
  assign bus.O_MI_OLD   = r_mi_old;
  assign bus.O_LI_NEW   = r_li_new;
  assign bus.O_MI_NEW   = r_mi_new;
  assign bus.O_COEF     = r_coef;
  assign bus.O_FIRST    = r_first;
  assign bus.O_ERR      = r_err;
  assign bus.O_LI_FINAL = r_li_fin;
  assign bus.O_MI_FINAL = r_mi_fin;

endmodule
`default_nettype wire

// File: doc/o_upd_seq_ctrl.md
Name: o_upd_seq_ctrl

Overview:
- Sequencer for the per-row output-rescale datapath in the tiled (flash-style) attention softmax.
- Walks NUM_TILES K/V tiles of one query block and keeps the running row statistics (l_i, m_i) in registers.
- For every tile after the first, presents old/new statistics to the rescale datapath, holds its enable until the datapath reports valid, and forwards the TIL rescale coefficients downstream over a valid/ready handshake.
- On completion, exposes the final l_i/m_i for the normalisation stage.

Parameters:
- D_W, 8, data width of m_i and of coefficients; l_i is 2*D_W.
- TIL, 16, rows per tile.
- NUM_TILES, 4, K/V tiles per query block (>=1).
- TMO, 63, maximum CALC cycles before timeout (>=1).

Ports:
- I_CLK  in  1  clock
- I_RST_N  in  1  synchronous active-low reset
- I_START  in  1  begin a query block; sampled only in IDLE
- I_TILE_VLD  in  1  new tile statistics valid
- O_TILE_RDY  out  1  controller ready to accept tile statistics
- I_LI_NEW  in  [2*D_W-1:0] x TIL  new running row sums
- I_MI_NEW  in  [D_W-1:0] x TIL  new running row maxima
- O_UPD_ENA  out  1  datapath enable, held through calculation
- O_LI_OLD / O_MI_OLD / O_LI_NEW / O_MI_NEW  out  x TIL  datapath operands, driven from registers
- I_UPD_VLD  in  1  datapath result valid
- I_COEF  in  [D_W-1:0] x TIL  datapath coefficients
- O_COEF_VLD  out  1  coefficient vector valid
- I_COEF_RDY  in  1  downstream accepts coefficients
- O_COEF  out  [D_W-1:0] x TIL  registered coefficients
- O_FIRST  out  1  qualifies O_COEF_VLD: first tile, no rescale (O_COEF all 0)
- O_ERR  out  1  sticky timeout flag; cleared by reset or accepted I_START
- O_BUSY  out  1  state != IDLE
- O_DONE  out  1  one-cycle pulse at block completion
- O_LI_FINAL  out  [2*D_W-1:0] x TIL  final l_i; valid from O_DONE until next I_START
- O_MI_FINAL  out  [D_W-1:0] x TIL  final m_i; same validity

Behaviour:
- Reset (I_RST_N=0 at a clock edge): state IDLE; all outputs 0; all stat/coef registers 0; tile_cnt=0, cyc_cnt=0. Reset wins over every other event and aborts any operation in flight.
- States: IDLE, WAIT_TILE, CALC, EMIT, DONE.
- IDLE: on I_START=1, clear old stats to 0, tile_cnt=0, O_ERR=0; next state WAIT_TILE.
- WAIT_TILE: O_TILE_RDY=1. On I_TILE_VLD&O_TILE_RDY, capture I_LI_NEW/I_MI_NEW into the new-stat regs.
  - If tile_cnt==0: O_COEF<=0, O_FIRST<=1, next state EMIT (datapath not used).
  - Otherwise: cyc_cnt=0, next state CALC.
- CALC: O_UPD_ENA=1 continuously. I_COEF is sampled only in this state.
  - On I_UPD_VLD=1: O_COEF<=I_COEF, O_FIRST<=0, next state EMIT. O_UPD_ENA is 0 in the following cycle.
  - If I_UPD_VLD=0 and cyc_cnt==TMO: O_COEF<=0, O_ERR<=1, next state EMIT.
  - Otherwise cyc_cnt++.
  - I_UPD_VLD and timeout in the same cycle: result wins, no error.
- EMIT: O_COEF_VLD=1; O_COEF/O_FIRST stable until I_COEF_RDY=1. On handshake:
  - old stats <= new stats, tile_cnt++.
  - Next state DONE if tile_cnt==NUM_TILES-1, else WAIT_TILE.
- DONE: O_DONE=1 for exactly one cycle; O_LI_FINAL/O_MI_FINAL <= new-stat regs; next state IDLE.
- Handshake and datapath rules:
  - O_UPD_ENA is low for at least 2 cycles between consecutive CALC visits (EMIT + WAIT_TILE), guaranteeing a datapath restart.
  - I_START outside IDLE is ignored; I_TILE_VLD outside WAIT_TILE is ignored; I_UPD_VLD outside CALC is ignored.
  - Fastest per-tile latency, tile accept to O_COEF_VLD: 1 cycle for the first tile; for later tiles, 1 cycle plus cycles in CALC until I_UPD_VLD.
- NUM_TILES=1: sequence is IDLE->WAIT_TILE->EMIT(first)->DONE; CALC is never entered.
- Width rules: no arithmetic on stats; pure register transfer. Counters sized $clog2(NUM_TILES+1) and $clog2(TMO+1).

Test Plan:
- Reset mid-CALC: assert I_RST_N=0 while O_UPD_ENA=1 -> next cycle O_UPD_ENA=0, O_BUSY=0, O_COEF=0, O_ERR=0.
- NUM_TILES=4, datapath model returns I_COEF[i]=i+1 three cycles after ENA. Tile 0 -> O_COEF_VLD with O_FIRST=1, O_COEF all 0; tiles 1-3 -> O_COEF[i]=i+1, O_FIRST=0. Also check per tile:
  - O_MI_OLD equals the previous tile's I_MI_NEW (e.g. 8'h10 then 8'h14);
  - O_DONE pulses once after the 4th handshake;
  - O_LI_FINAL equals tile-3 I_LI_NEW.
- Downstream backpressure: I_COEF_RDY=0 for 5 cycles in EMIT -> O_COEF_VLD stays 1 and O_COEF stays unchanged; O_TILE_RDY=0 until the handshake; tile_cnt increments once.
- Timeout: TMO=63, I_UPD_VLD never asserted -> CALC lasts 64 cycles; O_COEF=0; O_ERR=1 and stays set through DONE; next I_START clears it.
- Corner events: I_UPD_VLD and timeout in the same cycle -> O_ERR=0 with the datapath coefficient forwarded. I_START during CALC -> ignored, sequence unaffected. I_UPD_VLD during WAIT_TILE -> ignored.
- NUM_TILES=1: a single tile -> one O_FIRST coefficient vector, O_UPD_ENA never asserts, O_DONE follows the handshake.
